// File: rtl/cmd_resp_checker.sv
// SD CMD response checker: validates framing, index and bit-serial CRC7, then hands payload + status on.
// Optional index check enabled by defining CMD_RESP_IDX_CHECK_EN.
module cmd_resp_checker #(
    parameter int RESP_W = 136
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              strobe_in,
    output logic              ack_out,
    input  logic [RESP_W-1:0] response_in,
    input  logic [1:0]        resp_type,
    input  logic [5:0]        expected_index,
    output logic              strobe_out,
    input  logic              ack_in,
    output logic [119:0]      resp_out,
    output logic [3:0]        status
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMPARE, REPORT} state_t;

    state_t              state_q, state_d;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic [1:0]          type_q, type_d;
    logic [6:0]          crc_q, crc_d;
    logic [6:0]          cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                strobe_q, strobe_d;
    logic [119:0]        out_q, out_d;
    logic [3:0]          status_q, status_d;

`ifdef CMD_RESP_IDX_CHECK_EN
    logic [5:0]          idx_q, idx_d;
`else
    logic                unusedIdx;
    assign unusedIdx = ^expected_index;
`endif

    logic                isLong;
    logic [7:0]          bitPos;
    logic                shiftBit;
    logic                crcFb;
    logic [6:0]          crcNext;
    logic [6:0]          lastCnt;
    logic                startBad;
    logic [3:0]          statusNow;

    assign ack_out    = ack_q;
    assign strobe_out = strobe_q;
    assign resp_out   = out_q;
    assign status     = status_q;

    // Bit-serial CRC7 datapath; the bit under the counter is picked straight from the capture register.
    always_comb begin
        isLong   = (type_q == 2'b10);
        bitPos   = (isLong ? 8'd127 : 8'd47) - {1'b0, cnt_q};
        shiftBit = resp_q[bitPos];
        crcFb    = crc_q[6] ^ shiftBit;
        crcNext  = {crc_q[5:0], 1'b0} ^ (crcFb ? 7'h09 : 7'h00);
        lastCnt  = isLong ? 7'd119 : 7'd39;
        startBad = isLong ? (resp_q[135] | resp_q[134]) : (resp_q[47] | resp_q[46]);

        statusNow    = 4'b0000;
        statusNow[0] = (type_q != 2'b01) && (crc_q != resp_q[7:1]);
        statusNow[2] = ~resp_q[0];
        statusNow[3] = startBad
                     || ((type_q == 2'b01) && ((resp_q[45:40] != 6'h3F) || (resp_q[7:1] != 7'h7F)))
                     || (isLong && (resp_q[133:128] != 6'h3F));
`ifdef CMD_RESP_IDX_CHECK_EN
        statusNow[1] = (type_q == 2'b00) && (resp_q[45:40] != idx_q);
`endif
    end

    always_comb begin
        state_d  = state_q;
        resp_d   = resp_q;
        type_d   = type_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        strobe_d = strobe_q;
        out_d    = out_q;
        status_d = status_q;
`ifdef CMD_RESP_IDX_CHECK_EN
        idx_d    = idx_q;
`endif

        case (state_q)
            IDLE: begin
                if (strobe_in) begin
                    resp_d  = response_in;
                    type_d  = (resp_type == 2'b11) ? 2'b00 : resp_type;
`ifdef CMD_RESP_IDX_CHECK_EN
                    idx_d   = expected_index;
`endif
                    crc_d   = 7'h00;
                    cnt_d   = 7'd0;
                    ack_d   = 1'b1;
                    state_d = (resp_type == 2'b01) ? COMPARE : SHIFT;
                end
            end
            SHIFT: begin
                crc_d = crcNext;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == lastCnt) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                out_d    = isLong ? resp_q[127:8] : {88'b0, resp_q[39:8]};
                status_d = statusNow;
                strobe_d = 1'b1;
                state_d  = REPORT;
            end
            REPORT: begin
                if (ack_in) begin
                    strobe_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            resp_q   <= '0;
            type_q   <= 2'b00;
            crc_q    <= 7'h00;
            cnt_q    <= 7'd0;
            ack_q    <= 1'b0;
            strobe_q <= 1'b0;
            out_q    <= '0;
            status_q <= 4'b0000;
`ifdef CMD_RESP_IDX_CHECK_EN
            idx_q    <= 6'd0;
`endif
        end else begin
            state_q  <= state_d;
            resp_q   <= resp_d;
            type_q   <= type_d;
            crc_q    <= crc_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            strobe_q <= strobe_d;
            out_q    <= out_d;
            status_q <= status_d;
`ifdef CMD_RESP_IDX_CHECK_EN
            idx_q    <= idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_cmd_resp_checker.sv
// Directed bench for cmd_resp_checker; expected results queue up at capture and are checked when strobe_out rises.
module tb_cmd_resp_checker;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         strobe_in = 1'b0;
    logic         ack_out;
    logic [135:0] response_in = '0;
    logic [1:0]   resp_type = 2'b00;
    logic [5:0]   expected_index = 6'd0;
    logic         strobe_out;
    logic         ack_in = 1'b0;
    logic [119:0] resp_out;
    logic [3:0]   status;

`ifdef CMD_RESP_IDX_CHECK_EN
    localparam logic [3:0] IDX_ERR = 4'b0010;
`else
    localparam logic [3:0] IDX_ERR = 4'b0000;
`endif

    typedef struct {
        logic [119:0] resp;
        logic [3:0]   status;
        int           latency;
        int           captureEdge;
        string        tag;
    } exp_t;

    exp_t         sb[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           edgeCount = 0;
    logic [119:0] lastResp = '0;
    logic [3:0]   lastStatus = '0;

    cmd_resp_checker #(.RESP_W(136)) dut (
        .clock          (clock),
        .reset          (reset),
        .strobe_in      (strobe_in),
        .ack_out        (ack_out),
        .response_in    (response_in),
        .resp_type      (resp_type),
        .expected_index (expected_index),
        .strobe_out     (strobe_out),
        .ack_in         (ack_in),
        .resp_out       (resp_out),
        .status         (status)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edgeCount <= edgeCount + 1;

    task automatic compareValue(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [119:0] bits, input int n);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[6] ^ bits[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // Capture edge with inputs already driven; checks the ack pulse and queues the expectation.
    task automatic captureHeld(input logic [119:0] expResp, input logic [3:0] expStatus, input int expLat, input string tag);
        exp_t e;
        @(posedge clock);
        @(negedge clock);
        compareValue({tag, "_ack"}, {127'b0, ack_out}, 128'd1);
        strobe_in     = 1'b0;
        e.resp        = expResp;
        e.status      = expStatus;
        e.latency     = expLat;
        e.captureEdge = edgeCount;
        e.tag         = tag;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [135:0] resp, input logic [1:0] rtype, input logic [5:0] idx,
                                 input logic [119:0] expResp, input logic [3:0] expStatus, input int expLat,
                                 input string tag);
        @(negedge clock);
        response_in    = resp;
        resp_type      = rtype;
        expected_index = idx;
        strobe_in      = 1'b1;
        captureHeld(expResp, expStatus, expLat, tag);
    endtask

    task automatic checkOutput();
        exp_t e;
        int   waited;
        logic sawAck;
        waited = 0;
        sawAck = 1'b0;
        e = sb.pop_front();
        while (strobe_out !== 1'b1 && waited < 300) begin
            @(posedge clock);
            @(negedge clock);
            waited++;
            if (ack_out) sawAck = 1'b1;
        end
        compareValue({e.tag, "_strobe"}, {127'b0, strobe_out}, 128'd1);
        compareValue({e.tag, "_noack"}, {127'b0, sawAck}, 128'd0);
        compareValue({e.tag, "_latency"}, 128'(edgeCount - e.captureEdge), 128'(e.latency));
        compareValue({e.tag, "_resp"}, {8'b0, resp_out}, {8'b0, e.resp});
        compareValue({e.tag, "_status"}, {124'b0, status}, {124'b0, e.status});
        lastResp   = e.resp;
        lastStatus = e.status;
    endtask

    task automatic ackResult(input int holdCycles);
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clock);
            @(negedge clock);
            compareValue("hold", {3'b0, strobe_out, resp_out, status}, {3'b0, 1'b1, lastResp, lastStatus});
        end
        ack_in = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ack_in = 1'b0;
        compareValue("release", {127'b0, strobe_out}, 128'd0);
    endtask

    localparam logic [135:0] R7_GOOD  = {88'b0, 48'h08_0000_01AA_13};
    localparam logic [135:0] R7_CRC   = {88'b0, 48'h08_0000_01AA_15};
    localparam logic [135:0] R7_END   = {88'b0, 48'h08_0000_01AA_12};
    localparam logic [135:0] R7_START = {88'b0, 48'h88_0000_01AA_13};
    localparam logic [135:0] R3_GOOD  = {88'b0, 48'h3F_00FF_8000_FF};
    localparam logic [135:0] R3_BADIX = {88'b0, 48'h01_00FF_8000_FF};
    localparam logic [119:0] LONG_PAY = 120'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32;

    initial begin
        exp_t         dropped;
        logic [3:0]   startStatus;
        logic [135:0] longGood;

        $display("[TB] reset phase");
        #12;
        compareValue("reset_outputs", {6'b0, ack_out, strobe_out, resp_out, status}, 128'd0);
        @(negedge clock);
        reset = 1'b1;

        applyStimulus(R7_GOOD, 2'b00, 6'd8, 120'h1AA, 4'b0000, 41, "r7_good");
        checkOutput();
        ackResult(20);

        applyStimulus(R7_CRC, 2'b00, 6'd8, 120'h1AA, 4'b0001, 41, "r7_crc");
        checkOutput();
        ackResult(0);

        applyStimulus(R7_CRC, 2'b00, 6'd7, 120'h1AA, 4'b0001 | IDX_ERR, 41, "r7_crc_idx");
        checkOutput();
        ackResult(0);

        applyStimulus(R7_GOOD, 2'b00, 6'd9, 120'h1AA, IDX_ERR, 41, "r7_idx");
        checkOutput();
        ackResult(0);

        applyStimulus(R7_END, 2'b00, 6'd8, 120'h1AA, 4'b0100, 41, "r7_end");
        checkOutput();
        ackResult(0);

        startStatus = {1'b1, 2'b00, (crc7({80'b0, 40'h88_0000_01AA}, 40) != 7'h09)};
        applyStimulus(R7_START, 2'b00, 6'd8, 120'h1AA, startStatus, 41, "r7_start");
        checkOutput();
        ackResult(0);

        applyStimulus(R7_GOOD, 2'b11, 6'd8, 120'h1AA, 4'b0000, 41, "type11");
        checkOutput();
        ackResult(0);

        applyStimulus(R3_GOOD, 2'b01, 6'd0, 120'h00FF8000, 4'b0000, 1, "r3_good");
        checkOutput();
        ackResult(3);

        applyStimulus(R3_BADIX, 2'b01, 6'd0, 120'h00FF8000, 4'b1000, 1, "r3_badix");
        checkOutput();
        ackResult(0);

        applyStimulus({8'h3F, 120'h0, 8'h01}, 2'b10, 6'd0, 120'h0, 4'b0000, 121, "r2_zero");
        checkOutput();
        ackResult(0);

        applyStimulus({8'h3F, 120'h0, 8'h03}, 2'b10, 6'd0, 120'h0, 4'b0001, 121, "r2_crc");
        checkOutput();
        ackResult(0);

        longGood = {8'h3F, LONG_PAY, crc7(LONG_PAY, 120), 1'b1};
        applyStimulus(longGood, 2'b10, 6'd0, LONG_PAY, 4'b0000, 121, "r2_payload");
        checkOutput();
        ackResult(0);

        $display("[TB] strobe_in during SHIFT, then back-to-back capture");
        applyStimulus(R7_GOOD, 2'b00, 6'd8, 120'h1AA, 4'b0000, 41, "busy_first");
        repeat (10) @(negedge clock);
        response_in    = R3_GOOD;
        resp_type      = 2'b01;
        expected_index = 6'd0;
        strobe_in      = 1'b1;
        checkOutput();
        ackResult(0);
        captureHeld(120'h00FF8000, 4'b0000, 1, "busy_second");
        checkOutput();
        ackResult(0);

        $display("[TB] reset during SHIFT");
        applyStimulus(R7_GOOD, 2'b00, 6'd8, 120'h1AA, 4'b0000, 41, "aborted");
        repeat (20) @(negedge clock);
        reset = 1'b0;
        #1;
        compareValue("midreset_outputs", {6'b0, ack_out, strobe_out, resp_out, status}, 128'd0);
        dropped = sb.pop_back();
        #1;
        reset          = 1'b1;
        response_in    = R7_CRC;
        resp_type      = 2'b00;
        expected_index = 6'd8;
        strobe_in      = 1'b1;
        captureHeld(120'h1AA, 4'b0001, 41, "after_reset");
        checkOutput();
        ackResult(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
